// File: rtl/dma_mem_pkg.sv
// dma_mem_pkg: shared AXI widths, response/burst codes and FSM state types for the DMA memory slave
package dma_mem_pkg;
    localparam int AXI_ID_W   = 8;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/dma_mem_burst_addr.sv
// dma_mem_burst_addr: burst legality/range check plus per-beat next address and word index
module dma_mem_burst_addr
    import dma_mem_pkg::*;
#(
    parameter int                    MEM_DEPTH = 1024,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [AXI_ADDR_W-1:0]        chk_addr,
    input  logic [AXI_LEN_W-1:0]         chk_len,
    input  logic [2:0]                   chk_size,
    input  logic [1:0]                   chk_burst,
    output logic                         chk_err,
    input  logic [AXI_ADDR_W-1:0]        cur_addr,
    input  logic [1:0]                   cur_burst,
    output logic [AXI_ADDR_W-1:0]        nxt_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] cur_idx
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [AXI_ADDR_W:0] first_w;
    logic [AXI_ADDR_W:0] last_w;
    logic                unused_lsb;

    // Whole-burst legality: size, burst type, and word span of first..last beat inside the array
    always_comb begin
        first_w = {3'b000, chk_addr[AXI_ADDR_W-1:2]} - {3'b000, BASE_ADDR[AXI_ADDR_W-1:2]};
        last_w  = first_w + ((chk_burst == BURST_INCR) ? {25'd0, chk_len} : 33'd0);
        chk_err = (chk_size != 3'b010) || !(chk_burst inside {BURST_FIXED, BURST_INCR})
                  || first_w[AXI_ADDR_W] || (last_w >= 33'(MEM_DEPTH));
    end

    // Per-beat address step and word index (byte-offset bits ignored)
    always_comb begin
        nxt_addr = (cur_burst == BURST_INCR) ? cur_addr + 32'd4 : cur_addr;
        cur_idx  = cur_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    end

    assign unused_lsb = ^chk_addr[1:0];
endmodule

// File: rtl/dma_axi_mem_slave.sv
// dma_axi_mem_slave: AXI4 slave word memory with independent read/write FSMs; DMA_MEM_STALL_EN adds LFSR backpressure
module dma_axi_mem_slave
    import dma_mem_pkg::*;
#(
    parameter int                    MEM_DEPTH = 1024,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_W-1:0]   s_awid,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awlock,
    input  logic [3:0]            s_awcache,
    input  logic [2:0]            s_awprot,
    input  logic [3:0]            s_awqos,
    input  logic [3:0]            s_awregion,
    input  logic                  s_awuser,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [AXI_DATA_W-1:0] s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wuser,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [AXI_ID_W-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_buser,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_ID_W-1:0]   s_arid,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic [AXI_LEN_W-1:0]  s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arlock,
    input  logic [3:0]            s_arcache,
    input  logic [2:0]            s_arprot,
    input  logic [3:0]            s_arqos,
    input  logic [3:0]            s_arregion,
    input  logic                  s_aruser,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [AXI_ID_W-1:0]   s_rid,
    output logic [AXI_DATA_W-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_ruser,
    output logic                  s_rvalid,
    input  logic                  s_rready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [AXI_DATA_W-1:0] mem_q [MEM_DEPTH];
    logic                  stall;
    logic                  mem_we;

    wr_state_t             wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic [AXI_ID_W-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [AXI_ADDR_W-1:0] waddr_q, waddr_d;
    logic [AXI_LEN_W-1:0]  wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d;
    logic [8:0]            wcnt_q, wcnt_d;
    logic                  aw_err, w_last_beat;
    logic [AXI_ADDR_W-1:0] waddr_nxt;
    logic [IDX_W-1:0]      widx;

    rd_state_t             rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [AXI_ID_W-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    logic [AXI_ADDR_W-1:0] raddr_q, raddr_d;
    logic [AXI_LEN_W-1:0]  rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rerr_q, rerr_d;
    logic [8:0]            rcnt_q, rcnt_d;
    logic                  ar_err, ridle, ar_hs, r_hs, r_load, src_err;
    logic [AXI_ADDR_W-1:0] src_addr, raddr_nxt;
    logic [1:0]            src_burst;
    logic [AXI_LEN_W-1:0]  src_len;
    logic [8:0]            src_cnt;
    logic [IDX_W-1:0]      ridx;
    logic                  unused_side;

`ifdef DMA_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle to pace backpressure
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // LFSR register, reseeded on reset
    always_ff @(posedge clk) lfsr_q <= !rst ? 16'hACE1 : lfsr_d;

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    dma_mem_burst_addr #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_wr_addr (
        .chk_addr(s_awaddr), .chk_len(s_awlen), .chk_size(s_awsize), .chk_burst(s_awburst),
        .chk_err(aw_err), .cur_addr(waddr_q), .cur_burst(wburst_q),
        .nxt_addr(waddr_nxt), .cur_idx(widx)
    );

    dma_mem_burst_addr #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_rd_addr (
        .chk_addr(s_araddr), .chk_len(s_arlen), .chk_size(s_arsize), .chk_burst(s_arburst),
        .chk_err(ar_err), .cur_addr(src_addr), .cur_burst(src_burst),
        .nxt_addr(raddr_nxt), .cur_idx(ridx)
    );

    // Write FSM: accept AW, count W beats (data commits even on a misplaced wlast), then hold B
    always_comb begin
        wstate_d    = wstate_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wburst_d    = wburst_q;
        werr_d      = werr_q;
        wcnt_d      = wcnt_q;
        mem_we      = 1'b0;
        w_last_beat = wcnt_q == {1'b0, wlen_q};
        case (wstate_q)
            W_IDLE: if (s_awvalid && awready_q) begin
                wstate_d = W_DATA;
                bid_d    = s_awid;
                bresp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
                waddr_d  = s_awaddr;
                wlen_d   = s_awlen;
                wburst_d = s_awburst;
                werr_d   = aw_err;
                wcnt_d   = 9'd0;
            end
            W_DATA: if (s_wvalid && s_wready) begin
                mem_we  = rst && !werr_q;
                waddr_d = waddr_nxt;
                wcnt_d  = wcnt_q + 9'd1;
                if (s_wlast != w_last_beat) bresp_d = RESP_SLVERR;
                if (w_last_beat) wstate_d = W_RESP;
            end
            W_RESP: if (s_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        awready_d = wstate_d == W_IDLE;
    end

    // Write channel registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= BURST_FIXED;
            werr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Byte-lane memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem_q[widx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    // Read FSM: the next beat comes from the AR payload when idle, else from the captured burst
    always_comb begin
        ridle     = rstate_q == R_IDLE;
        src_addr  = ridle ? s_araddr : raddr_q;
        src_burst = ridle ? s_arburst : rburst_q;
        src_len   = ridle ? s_arlen : rlen_q;
        src_err   = ridle ? ar_err : rerr_q;
        src_cnt   = ridle ? 9'd0 : rcnt_q;
        ar_hs     = ridle && s_arvalid && arready_q;
        r_hs      = rvalid_q && s_rready;
        r_load    = !stall && (ar_hs || (!ridle && (!rvalid_q || s_rready) && rcnt_q <= {1'b0, rlen_q}));
        rstate_d  = rstate_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rcnt_d    = rcnt_q;
        if (ar_hs) begin
            rstate_d = R_DATA;
            rid_d    = s_arid;
            rresp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
            raddr_d  = s_araddr;
            rlen_d   = s_arlen;
            rburst_d = s_arburst;
            rerr_d   = ar_err;
            rcnt_d   = 9'd0;
        end
        if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            if (rlast_q) rstate_d = R_IDLE;
        end
        if (r_load) begin
            rvalid_d = 1'b1;
            rdata_d  = src_err ? '0 : mem_q[ridx];
            rlast_d  = src_cnt == {1'b0, src_len};
            raddr_d  = raddr_nxt;
            rcnt_d   = src_cnt + 9'd1;
        end
        arready_d = rstate_d == R_IDLE;
    end

    // Read channel registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= BURST_FIXED;
            rerr_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = (wstate_q == W_DATA) && !stall;
    assign s_bvalid  = wstate_q == W_RESP;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_buser   = 1'b0;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rlast   = rlast_q;
    assign s_rid     = rid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign s_ruser   = 1'b0;

    assign unused_side = ^{s_awlock, s_awcache, s_awprot, s_awqos, s_awregion, s_awuser, s_wuser,
                           s_arlock, s_arcache, s_arprot, s_arqos, s_arregion, s_aruser};
endmodule

// File: doc/dma_axi_mem_slave.md
# dma_axi_mem_slave

AXI4 slave memory model that sits directly downstream of the DMA master port and serves its read and write bursts from an internal word array. It is the DMA's source and destination memory in the block-level bench and the FPGA bring-up image. Read and write channels run independently, each with its own state machine. It returns OKAY or SLVERR per burst.

## Interface
- MEM_DEPTH, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- s_awid / s_awaddr / s_awlen / s_awsize / s_awburst  input  8/32/8/3/2  AW payload.
- s_awvalid  input  1;  s_awready  output  1.
- s_wdata / s_wstrb / s_wlast  input  32/4/1;  s_wvalid  input  1;  s_wready  output  1.
- s_bid / s_bresp  output  8/2;  s_bvalid  output  1;  s_bready  input  1.
- s_arid / s_araddr / s_arlen / s_arsize / s_arburst  input  8/32/8/3/2  AR payload.
- s_arvalid  input  1;  s_arready  output  1.
- s_rid / s_rdata / s_rresp / s_rlast  output  8/32/2/1;  s_rvalid  output  1;  s_rready  input  1.
- s_awlock/cache/prot/qos/region/user, s_wuser, s_arlock/cache/prot/qos/region/user  input  various  accepted, ignored.
- s_buser, s_ruser  output  1  tied 0.

## Operation
- Write FSM: W_IDLE -> W_DATA on AW handshake -> W_RESP after beat awlen+1 -> W_IDLE on B handshake.
- Read FSM: R_IDLE -> R_DATA on AR handshake -> R_IDLE on the handshake of beat arlen.
- Legality check at AW/AR acceptance. SLVERR (2'b10) for the whole burst if any of these hold:
  - size != 3'b010;
  - burst is WRAP or reserved;
  - any beat address is outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH).
- Error bursts still run all beats. Writes are suppressed and reads return 0.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits. Address bits [1:0] are ignored.
- INCR: the address advances by 4 per beat. FIXED: the address is constant.
- Write beats commit only the byte lanes set in wstrb.
- Beat count alone terminates a write burst. If wlast is not asserted exactly on beat awlen, bresp is SLVERR; the data is still written.
- bid = captured awid; rid = captured arid.
- A read and a write to the same word in the same cycle: the read returns the old data.
- Memory contents are not reset.

## Timing
- During reset, every output is 0: awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast.
- awready and arready are 1 in the first cycle after rst deasserts. They are registered and high only in W_IDLE / R_IDLE.
- Write path:
  - The AW handshake in cycle N gives wready = 1 from cycle N+1.
  - Back-to-back W beats are accepted every cycle.
  - bvalid rises the cycle after the last W handshake and holds, with bid and bresp stable, until bready.
  - awready returns the cycle after the B handshake.
- Read path:
  - The AR handshake in cycle N gives rvalid = 1 with beat 0 in cycle N+1.
  - While rready is high, one beat is delivered per cycle.
  - rdata, rid, rresp and rlast hold while rvalid && !rready.
  - rlast is set only on beat arlen.
  - rvalid falls the cycle after the last handshake. arready rises in the same cycle.
- awlen = 0 and arlen = 0 are single-beat bursts.
- A 256-beat burst (len = 8'hFF) uses a 9-bit beat counter with no wrap.
- Reset mid-burst aborts both FSMs with no response. Partially written data remains.

## Configuration
- DMA_MEM_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle) injects backpressure.
  - When LFSR bit 0 = 1, wready is forced low for that cycle.
  - When LFSR bit 0 = 1, presentation of the next R beat is delayed. This can only happen while rvalid is low or in the cycle after a handshake, so rvalid is never withdrawn before its handshake.
- DMA_MEM_STALL_EN undefined: no LFSR logic is present and the timing is exactly as above.

## Structure
- Package dma_mem_pkg holds:
  - AXI_ID_W = 8, AXI_ADDR_W = 32, AXI_DATA_W = 32, AXI_LEN_W = 8;
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - burst constants BURST_FIXED = 2'b00, BURST_INCR = 2'b01;
  - the wr_state_t and rd_state_t enums.
- One sub-module, dma_mem_burst_addr: a combinational next-address and range/legality checker, instantiated once per channel.

## Test plan
- INCR write, awaddr 0x100, awlen 3, wdata 0xA0..0xA3, wstrb 4'hF -> 4 wready beats, then bresp 00 and bid = awid. INCR read of the same range -> 0xA0..0xA3 with rlast on beat 3.
- Partial strobe: write 0xDEADBEEF with wstrb 4'b0101 to a word preset to 0 -> a read returns 0x00AD00EF.
- Range error: awaddr = BASE_ADDR + 4*MEM_DEPTH - 4 with awlen 1 -> bresp 10 and no memory change. arsize 3'b001 -> both beats return rresp 10 and rdata 0.
- Read backpressure: arlen 7 with rready toggled 1,0,1,0... -> 8 beats, stable during stalls, rlast only on the eighth, arready low until the cycle after the last beat.
- Concurrency: a 16-beat write and a 16-beat read issued in the same cycle to disjoint regions -> both complete with OKAY and the read returns the prior contents. wlast asserted early on beat 2 of 4 -> all 4 beats written and bresp 10.
- Reset asserted on read beat 2 of 4 -> rvalid = 0 the next cycle and arready = 1 the cycle after rst deasserts. With DMA_MEM_STALL_EN: a 64-beat write/read-back matches data with stalls observed.
